// File: rtl/wrr_arb_if.sv
// Request/grant bundle between clients (master) and the weighted round-robin arbiter (slave).
interface wrr_arb_if #(
  parameter int N  = 4,
  parameter int WW = 4
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    req;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_id;
  logic            gnt_vld;

  // Client side: raises requests and supplies weights, observes grants.
  modport master (
    output req, weight,
    input  gnt, gnt_id, gnt_vld
  );

  // Arbiter side: samples requests and weights, drives grants.
  modport slave (
    input  req, weight,
    output gnt, gnt_id, gnt_vld
  );
endinterface

// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter: registered one-hot grant held for a burst of up to
// weight[owner] cycles, then ownership rotates to the next requester after the owner.
module wrr_arb #(
  parameter int N  = 4,
  parameter int WW = 4
) (
  input  logic       clk,
  input  logic       rst,
  wrr_arb_if.slave   bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wlat_q, wlat_d;
  logic [N-1:0]  gnt_q, gnt_d;

  logic [IW-1:0] next_o;
  logic [IW-1:0] search_start;
  logic [IW:0]   cand;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic [WW-1:0] hit_weight;
  logic          hold;

  // Circular search for the first requester starting at ptr (idle) or owner+1 (releasing).
  always_comb begin
    next_o       = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
    search_start = (state_q == GRANT) ? next_o : ptr_q;
    hit          = 1'b0;
    hit_idx      = '0;
    cand         = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, search_start} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) begin
        cand = cand - (IW + 1)'(N);
      end
      if (!hit && bus.req[cand[IW-1:0]]) begin
        hit     = 1'b1;
        hit_idx = cand[IW-1:0];
      end
    end
    hit_weight = bus.weight[int'(hit_idx) * WW +: WW];
  end

  // Next-state logic: hold the burst while the owner still requests and has budget left,
  // otherwise hand over in the same cycle (no bubble) or drop to idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    wlat_d  = wlat_q;
    gnt_d   = gnt_q;
    hold    = (state_q == GRANT) && bus.req[id_q] && (cnt_q < wlat_q);

    if (hold) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      if (state_q == GRANT) begin
        ptr_d = next_o;
      end
      if (hit) begin
        state_d = GRANT;
        id_d    = hit_idx;
        cnt_d   = WW'(1);
        wlat_d  = (hit_weight == '0) ? WW'(1) : hit_weight;
        gnt_d   = N'(1) << hit_idx;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
      end
    end
  end

  // State register with synchronous reset; reset aborts any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      wlat_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      wlat_q  <= wlat_d;
      gnt_q   <= gnt_d;
    end
  end

  // Outputs come straight from registers; gnt_id keeps its last value while idle.
  always_comb begin
    bus.gnt     = gnt_q;
    bus.gnt_id  = id_q;
    bus.gnt_vld = |gnt_q;
  end
endmodule

// File: tb/tb_wrr_arb.sv
// Self-checking bench for wrr_arb: reference model feeds a scoreboard queue, plus
// directed spot checks and invariant checks over a random phase.
module tb_wrr_arb;
  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = $clog2(N);

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [IW-1:0] id;
    logic          vld;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wrr_arb_if #(.N(N), .WW(WW)) bus ();

  wrr_arb #(.N(N), .WW(WW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // Reference model state
  bit   m_busy = 1'b0;
  int   m_ptr  = 0;
  int   m_id   = 0;
  int   m_cnt  = 0;
  int   m_wlat = 0;

  logic [N-1:0] last_gnt;
  int           step_no = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (step %0d)", tag, got, exp, step_no);
    end
  endtask

  task automatic model_step(input bit r, input logic [N-1:0] rq, input logic [N*WW-1:0] wt);
    int s;
    int w;
    if (r) begin
      m_busy = 1'b0; m_ptr = 0; m_id = 0; m_cnt = 0; m_wlat = 0;
      return;
    end
    if (m_busy && rq[m_id] && (m_cnt < m_wlat)) begin
      m_cnt++;
      return;
    end
    if (m_busy) begin
      s     = (m_id + 1) % N;
      m_ptr = s;
    end else begin
      s = m_ptr;
    end
    w = -1;
    for (int k = 0; k < N; k++) begin
      if (w < 0 && rq[(s + k) % N]) w = (s + k) % N;
    end
    if (w >= 0) begin
      m_busy = 1'b1;
      m_id   = w;
      m_cnt  = 1;
      m_wlat = int'(wt[w*WW +: WW]);
      if (m_wlat == 0) m_wlat = 1;
    end else begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end
  endtask

  // One transaction: drive at negedge, push model expectation, compare after posedge.
  task automatic step(input bit r, input logic [N-1:0] rq, input logic [N*WW-1:0] wt);
    exp_t e;
    @(negedge clk);
    rst        = r;
    bus.req    = rq;
    bus.weight = wt;
    model_step(r, rq, wt);
    e.gnt = m_busy ? (N'(1) << m_id) : '0;
    e.id  = IW'(m_id);
    e.vld = m_busy;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk("gnt", 32'(bus.gnt), 32'(e.gnt));
      chk("gnt_id", 32'(bus.gnt_id), 32'(e.id));
      chk("gnt_vld", 32'(bus.gnt_vld), 32'(e.vld));
    end
    last_gnt = bus.gnt;
    $display("step %0d rst=%0b req=%b weight=%h gnt=%b id=%0d vld=%0b",
             step_no, r, rq, wt, bus.gnt, bus.gnt_id, bus.gnt_vld);
  endtask

  logic [N-1:0]    rq;
  logic [N*WW-1:0] wt;
  logic [N-1:0]    exp_seq1 [5];
  logic [N-1:0]    exp_seq2 [10];
  int              run_len;
  int              run_wlat;
  logic [N-1:0]    prev_gnt;
  int              wait_cnt [N];
  int              max_wait;
  int              bound;

  initial begin
    bus.req    = '0;
    bus.weight = '0;
    last_gnt   = '0;

    // Reset state
    step(1'b1, 4'b0000, 16'h0000);
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_vld", 32'(bus.gnt_vld), 32'd0);
    chk("reset_id", 32'(bus.gnt_id), 32'd0);

    // 1: all weights 1, plain round robin one cycle each
    exp_seq1 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b1111, 16'h1111);
      chk("t1_seq", 32'(last_gnt), 32'(exp_seq1[i]));
    end

    // 2: weights {4,3,2,1}: 1,2,3,4 cycle bursts, gnt_vld continuous
    step(1'b1, 4'b0000, 16'h4321);
    exp_seq2 = '{4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100,
                 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < 10; i++) begin
        step(1'b0, 4'b1111, 16'h4321);
        chk("t2_seq", 32'(last_gnt), 32'(exp_seq2[i]));
        chk("t2_vld", 32'(bus.gnt_vld), 32'd1);
      end
    end

    // 3: sole requester 2, weight 2: continuous grant, no gap
    step(1'b1, 4'b0000, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'b0100, 16'h0200);
      chk("t3_gnt", 32'(last_gnt), 32'h4);
      chk("t3_id", 32'(bus.gnt_id), 32'd2);
    end

    // 4: client 1 (weight 4) drops after 2 cycles with client 3 pending
    step(1'b1, 4'b0000, 16'h4444);
    step(1'b0, 4'b0010, 16'h4444);
    chk("t4_own1", 32'(last_gnt), 32'h2);
    step(1'b0, 4'b1010, 16'h4444);
    chk("t4_hold1", 32'(last_gnt), 32'h2);
    step(1'b0, 4'b1000, 16'h4444);
    chk("t4_handover", 32'(last_gnt), 32'h8);

    // 5: weight 0 behaves as 1
    step(1'b1, 4'b0000, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'b0011, 16'h0010);
      chk("t5_alt", 32'(last_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
    end

    // 6: reset mid-burst of client 2, then pointer back at 0
    step(1'b1, 4'b0000, 16'h4444);
    step(1'b0, 4'b0100, 16'h4444);
    step(1'b0, 4'b0100, 16'h4444);
    chk("t6_burst", 32'(last_gnt), 32'h4);
    step(1'b1, 4'b0100, 16'h4444);
    chk("t6_rst_gnt", 32'(last_gnt), 32'h0);
    chk("t6_rst_vld", 32'(bus.gnt_vld), 32'd0);
    step(1'b0, 4'b1111, 16'h4444);
    chk("t6_first", 32'(last_gnt), 32'h1);

    // 7: random requests (sticky) and weights, with invariant checks
    step(1'b1, 4'b0000, 16'h0000);
    rq       = 4'b1010;
    wt       = 16'h2135;
    prev_gnt = '0;
    run_len  = 0;
    run_wlat = 0;
    max_wait = 0;
    bound    = N * ((1 << WW) - 1);
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) rq[i] = ~rq[i];
        if ($urandom_range(15) == 0) wt[i*WW +: WW] = WW'($urandom_range((1 << WW) - 1));
      end
      step(1'b0, rq, wt);
      chk("r_onehot", 32'($countones(last_gnt) <= 1), 32'd1);
      chk("r_gnt_req", 32'(last_gnt & ~rq), 32'd0);
      if (last_gnt == '0) begin
        run_len = 0;
      end else if (last_gnt != prev_gnt) begin
        run_len  = 1;
        run_wlat = int'(wt[int'(bus.gnt_id)*WW +: WW]);
        if (run_wlat == 0) run_wlat = 1;
      end else begin
        run_len++;
        if (run_len > run_wlat) begin
          // Only a sole requester may be regranted back-to-back past its budget.
          chk("r_burst_len", 32'(rq & ~last_gnt), 32'd0);
          run_len  = 1;
          run_wlat = int'(wt[int'(bus.gnt_id)*WW +: WW]);
          if (run_wlat == 0) run_wlat = 1;
        end
      end
      prev_gnt = last_gnt;
      for (int i = 0; i < N; i++) begin
        if (rq[i] && !last_gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    chk("r_starve", 32'(max_wait <= bound), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
